or_reduce_pipe: RTL
===================

// Module: or_reduce_pipe
// PURPOSE
//  Pipelined, parametrised OR-reduction. Accepts LANES words of WIDTH bits per beat and returns
//  their bitwise OR. Output is out = |{in[0..LANES-1]} per bit. Structure is a registered binary
//  tree, one level per cycle, with valid/ready flow control. Sits between multi-source flag/status
//  collectors and downstream consumers, and replaces single-bit combinational OR gates where
//  fan-in and timing require it.
// PARAMETERS
//  WIDTH   8  bits per lane, >=1
//  LANES   4  input words per beat; power of two, >=2
//  LEVELS  $clog2(LANES)  derived localparam, not overridable; equals pipeline latency
// PORTS
//  clk        in   1             rising-edge clock
//  rst        in   1             synchronous reset, active-high
//  in_valid   in   1             input beat valid
//  in_ready   out  1             block can accept a beat this cycle
//  in_data    in   LANES*WIDTH   lane k at bits [k*WIDTH +: WIDTH]
//  out_valid  out  1             result valid
//  out_ready  in   1             consumer accepts result
//  out_data   out  WIDTH         bitwise OR of all lanes of one beat
//  acc_clr    in   1             (STICKY_ACC_EN only) clear sticky accumulator
//  acc_data   out  WIDTH         (STICKY_ACC_EN only) OR of all delivered results since clear
// BEHAVIOUR
//  - Reset: all stage valid bits=0, stage data=0. out_valid=0, out_data=0, acc_data=0.
//    in_ready=1 in the first cycle after reset deasserts.
//  - adv = out_ready | ~out_valid. in_ready = adv (global stall; no bubble squeezing).
//  - in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
//  - adv=1: level 0 captures pairwise OR of in_data lanes and valid<=in_fire. Level i captures
//    pairwise OR of level i-1 and its valid. Last level drives out_data/out_valid.
//  - adv=0: every stage holds data and valid. out_data is stable while out_valid & ~out_ready.
//  - Latency: a beat accepted at edge t is presented at edge t+LEVELS-1. Out_valid is visible in
//    the cycle after edge t+LEVELS-1 (LANES=4: 2 edges). Throughput is 1 beat/cycle when out_ready=1.
//  - Order is preserved. No beat is dropped or duplicated.
//  - in_valid while in_ready=0: no capture; the source must hold in_data.
//  - Data of invalid stages is don't-care to consumers but must not be X after reset.
//  - Reset mid-operation: all in-flight beats are discarded, and a beat presented during rst is
//    not accepted.
//  - Width rule: the OR is per bit; no width growth. Lane index k maps straight to the tree leaf.
// CONFIGURATION
//  - Macro OR_REDUCE_STICKY_ACC_EN.
//  - Defined: adds acc_clr/acc_data and the register
//      acc <= acc_clr ? (out_fire ? out_data : 0) : (out_fire ? acc|out_data : acc).
//    acc_clr and out_fire together: the new result survives the clear.
//  - Undefined: no acc_clr/acc_data ports and no accumulator flops. All other behaviour is
//    identical.
// STRUCTURE
//  - Package or_pkg: function clog2 and localparam helpers for LEVELS. Shared by later
//    and/xor reduction variants.
//  - Sub-module or_level #(WIDTH, N_IN): one tree level, N_IN lanes -> N_IN/2 registered lanes
//    with valid and enable. Generate LEVELS instances with halving N_IN.
//  - Per-bit OR is built from the team's NAND-based or_gate, instantiated inside or_level.
// TESTING (WIDTH=8, LANES=4 unless noted)
//  - Basic: in_data lanes 01,02,04,80 with out_ready=1 -> out_data=87, out_valid high exactly 2
//    cycles after in_fire.
//  - Streaming: 4 back-to-back beats with all-zero, FF in lane 3, 10 in lanes 0 and 2, all-zero ->
//    results 00,FF,10,00 in order on consecutive cycles.
//  - Backpressure: out_ready=0 for 5 cycles with 3 beats pending -> in_ready=0, out_data held
//    constant. On release, 3 results drain in order with none lost.
//  - Reset mid-flight: rst for 1 cycle with 2 beats in the pipe -> out_valid=0 next cycle, no
//    stale result appears afterwards.
//  - Sticky (macro on): results 01 then 40 -> acc_data=41. acc_clr together with result 08 ->
//    acc_data=08.
//  - Param sweep: LANES=2 (latency 1) and LANES=16, WIDTH=1 (latency 4). Random beats are checked
//    against a reference model.

Source files
------------

// File: rtl/or_pkg.sv
// Shared helpers for the pipelined reduction family (or/and/xor variants).
// Provides the tree depth and per-level lane count used by the top levels.
package or_pkg;

  // Ceiling log2 for elaboration-time sizing; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Number of lanes entering tree level `level` for a tree with `lanes` leaves.
  function automatic int lanes_at_level(input int lanes, input int level);
    return lanes >> level;
  endfunction

endpackage

// File: rtl/or_gate.sv
// Bitwise two-input OR built from inverters and a NAND: a | b == ~(~a & ~b).
module or_gate #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] a_n;
  logic [WIDTH-1:0] b_n;

  assign a_n = ~a;
  assign b_n = ~b;
  assign y   = ~(a_n & b_n);

endmodule

// File: rtl/or_level.sv
// One registered level of the OR tree: N_IN lanes in, N_IN/2 lanes out.
// Adjacent lane pairs (2k, 2k+1) are ORed into output lane k.
module or_level #(
  parameter int WIDTH = 8,
  parameter int N_IN  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic [N_IN*WIDTH-1:0]   in_data,
  output logic                    out_valid,
  output logic [N_IN/2*WIDTH-1:0] out_data
);

  localparam int N_OUT = N_IN / 2;

  logic [N_OUT*WIDTH-1:0] pair_or;

  for (genvar k = 0; k < N_OUT; k++) begin : g_pair
    or_gate #(.WIDTH(WIDTH)) u_or (
      .a (in_data[(2*k)*WIDTH   +: WIDTH]),
      .b (in_data[(2*k+1)*WIDTH +: WIDTH]),
      .y (pair_or[k*WIDTH       +: WIDTH])
    );
  end

  // Stage register: capture pair ORs and valid when the pipe advances, else hold.
  // NOTE: sequential state uses non-blocking assignments so all levels update
  // from pre-edge values and the tree shifts one level per clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      // NOTE: data is reset as well as valid so an idle stage never shows X
      // to downstream logic, even though its contents are don't-care.
      out_data  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_data  <= pair_or;
    end
  end

endmodule

// File: rtl/or_reduce_pipe.sv
// Pipelined OR-reduction of LANES words of WIDTH bits with valid/ready flow control.
// Latency is LEVELS = clog2(LANES) cycles; one beat per cycle when out_ready is high.
// Optional sticky accumulator of delivered results: define OR_REDUCE_STICKY_ACC_EN.
module or_reduce_pipe
  import or_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data
`ifdef OR_REDUCE_STICKY_ACC_EN
  ,
  input  logic                   acc_clr,
  output logic [WIDTH-1:0]       acc_data
`endif
);

  localparam int LEVELS = clog2(LANES);

  logic adv;
  logic in_fire;

  // Global stall: the whole tree moves only when the output slot is free or draining.
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;
  assign in_fire  = in_valid & in_ready;

  for (genvar g = 0; g < LEVELS; g++) begin : lvl
    localparam int N_IN = lanes_at_level(LANES, g);

    logic                    v_in;
    logic [N_IN*WIDTH-1:0]   d_in;
    logic                    v_out;
    logic [N_IN/2*WIDTH-1:0] d_out;

    if (g == 0) begin : g_src
      assign v_in = in_fire;
      assign d_in = in_data;
    end else begin : g_src
      assign v_in = lvl[g-1].v_out;
      assign d_in = lvl[g-1].d_out;
    end

    or_level #(.WIDTH(WIDTH), .N_IN(N_IN)) u_level (
      .clk       (clk),
      .rst       (rst),
      .en        (adv),
      .in_valid  (v_in),
      .in_data   (d_in),
      .out_valid (v_out),
      .out_data  (d_out)
    );
  end

  assign out_valid = lvl[LEVELS-1].v_out;
  assign out_data  = lvl[LEVELS-1].d_out;

`ifdef OR_REDUCE_STICKY_ACC_EN
  logic             out_fire;
  logic [WIDTH-1:0] acc;

  assign out_fire = out_valid & out_ready;
  assign acc_data = acc;

  // Sticky accumulator of delivered results; a result delivered with the clear survives it.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (acc_clr) begin
      acc <= out_fire ? out_data : '0;
    end else if (out_fire) begin
      acc <= acc | out_data;
    end
  end
`else
  // No accumulator in this build.
`endif

endmodule
